// File: rtl/mat_operand_loader.sv
// mat_operand_loader: serial-to-parallel operand feeder for the 5x2 x 2x4
// matrix multiplier. Streams 10 A elements then 8 B elements (row-major) in
// over valid/ready, packs them MSB-first into a_bus/b_bus, freezes the buses
// for LATENCY edges, flags res_valid and waits for res_ack.
// Optional: define MAT_LOADER_FLUSH_EN to add a synchronous flush input.
module mat_operand_loader #(
  parameter int W       = 12,
  parameter int ROWS_A  = 5,
  parameter int K       = 2,
  parameter int COLS_B  = 4,
  parameter int LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [W-1:0]                  in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [ROWS_A*K*W-1:0]         a_bus,
  output logic [K*COLS_B*W-1:0]         b_bus,
  output logic                          mat_valid,
  output logic                          res_valid,
  input  logic                          res_ack
`ifdef MAT_LOADER_FLUSH_EN
  ,
  input  logic                          flush
`endif
);

  localparam int NA = ROWS_A * K;
  localparam int NB = K * COLS_B;
  localparam int EW = $clog2((NA > NB) ? NA : NB);
  localparam int HW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_LOAD_A, S_LOAD_B, S_HOLD, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [EW-1:0]       e_q, e_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [NA*W-1:0]     a_bus_q, a_bus_d;
  logic [NB*W-1:0]     b_bus_q, b_bus_d;
  logic                mat_valid_q, mat_valid_d;
  logic                res_valid_q, res_valid_d;
  logic                xfer;

  // in_ready is a pure state decode so it never depends on in_valid
  assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign xfer      = in_valid && in_ready;
  assign a_bus     = a_bus_q;
  assign b_bus     = b_bus_q;
  assign mat_valid = mat_valid_q;
  assign res_valid = res_valid_q;

  // Next-state, slot packing and registered-output decode
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    hold_d  = hold_q;
    a_bus_d = a_bus_q;
    b_bus_d = b_bus_q;
    case (state_q)
      S_LOAD_A: if (xfer) begin
        // element 0 lands in the MSBs
        a_bus_d[(NA-1-int'(e_q))*W +: W] = in_data;
        if (e_q == EW'(NA-1)) begin
          e_d     = '0;
          state_d = S_LOAD_B;
        end else begin
          e_d = e_q + 1'b1;
        end
      end
      S_LOAD_B: if (xfer) begin
        b_bus_d[(NB-1-int'(e_q))*W +: W] = in_data;
        if (e_q == EW'(NB-1)) begin
          e_d     = '0;
          hold_d  = '0;
          state_d = S_HOLD;
        end else begin
          e_d = e_q + 1'b1;
        end
      end
      S_HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(LATENCY-1)) state_d = S_WAIT;
      end
      S_WAIT: if (res_ack) state_d = S_LOAD_A;
      default: state_d = S_LOAD_A;
    endcase
`ifdef MAT_LOADER_FLUSH_EN
    // flush wins over any transfer or ack; bus contents are left alone
    if (flush) begin
      state_d = S_LOAD_A;
      e_d     = '0;
      hold_d  = '0;
    end
`endif
    mat_valid_d = (state_d == S_HOLD) || (state_d == S_WAIT);
    res_valid_d = (state_d == S_WAIT);
  end

  // State and output registers, async active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD_A;
      e_q         <= '0;
      hold_q      <= '0;
      a_bus_q     <= '0;
      b_bus_q     <= '0;
      mat_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      e_q         <= e_d;
      hold_q      <= hold_d;
      a_bus_q     <= a_bus_d;
      b_bus_q     <= b_bus_d;
      mat_valid_q <= mat_valid_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed bench for mat_operand_loader: vector table of operand sets plus
// hand sequences for async reset mid-load and (optionally) flush.
module tb_mat_operand_loader;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [119:0]   a_bus;
  logic [95:0]    b_bus;
  logic           mat_valid, res_valid;
  logic           res_ack = 1'b0;
  logic           flush = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mat_operand_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a_bus(a_bus), .b_bus(b_bus),
    .mat_valid(mat_valid), .res_valid(res_valid), .res_ack(res_ack)
`ifdef MAT_LOADER_FLUSH_EN
    , .flush(flush)
`endif
  );

  typedef struct {
    logic [W-1:0] a0;      // first A element
    logic [W-1:0] b0;      // first B element
    logic [W-1:0] step;    // increment between consecutive elements
    bit           gaps;    // random in_valid drops
    int           ack_dly; // WAIT cycles before res_ack
    logic [W-1:0] a_hi, a_lo, b_hi, b_lo; // expected corner slots
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [119:0] exp_a(input logic [W-1:0] a0, input logic [W-1:0] st);
    logic [119:0] r = '0;
    for (int e = 0; e < 10; e++) r[(9-e)*W +: W] = W'(a0 + st*W'(e));
    return r;
  endfunction

  function automatic logic [95:0] exp_b(input logic [W-1:0] b0, input logic [W-1:0] st);
    logic [95:0] r = '0;
    for (int e = 0; e < 8; e++) r[(7-e)*W +: W] = W'(b0 + st*W'(e));
    return r;
  endfunction

  // Stream up to nmax elements of a set; returns right after the last accepting edge.
  task automatic load_set(input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] st, input bit gaps, input int nmax);
    int n = 0;
    int cyc = 0;
    bit x;
    while (n < nmax && cyc < 400) begin
      @(negedge clk);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = (n < 10) ? W'(a0 + st*W'(n)) : W'(b0 + st*W'(n-10));
      x = in_valid && in_ready;
      @(posedge clk);
      if (x) n++;
      cyc++;
    end
    if (n != nmax) begin
      bad++;
      $display("FAIL load_timeout: transfers %0d expected %0d", n, nmax);
    end
    total++;
  endtask

  task automatic run_vec(input vec_t v);
    load_set(v.a0, v.b0, v.step, v.gaps, 18);
    // edge T just passed; drive junk that must never be captured
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'hABC;
    chk("mat_valid_T+1", mat_valid, 1);
    chk("res_valid_T+1", res_valid, 0);
    chk("in_ready_hold", in_ready, 0);
    @(negedge clk);
    chk("res_valid_T+1e", res_valid, 0);
    chk("mat_valid_T+1e", mat_valid, 1);
    @(negedge clk);
    chk("res_valid_T+2", res_valid, 1);
    for (int i = 0; i < v.ack_dly; i++) begin
      @(negedge clk);
      chk("res_valid_wait", res_valid, 1);
      chk("in_ready_wait", in_ready, 0);
    end
    chk("a_bus", a_bus, exp_a(v.a0, v.step));
    chk("b_bus", b_bus, exp_b(v.b0, v.step));
    chk("a_hi", a_bus[119:108], v.a_hi);
    chk("a_lo", a_bus[11:0], v.a_lo);
    chk("b_hi", b_bus[95:84], v.b_hi);
    chk("b_lo", b_bus[11:0], v.b_lo);
    if (v.step == 0) begin
      // end-to-end: multiplier C(i,j) = sum_k A(i,k)*B(k,j), 12-bit result
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 4; j++) begin
          logic [W-1:0] c;
          c = W'(a_bus[(9-(i*2))*W +: W] * b_bus[(7-j)*W +: W]
               + a_bus[(9-(i*2+1))*W +: W] * b_bus[(7-(4+j))*W +: W]);
          chk("c_elem", c, W'(v.a0 * v.b0 * 2));
        end
    end
    res_ack = 1'b1;
    @(negedge clk);
    res_ack  = 1'b0;
    in_valid = 1'b0;
    chk("res_valid_ack", res_valid, 0);
    chk("mat_valid_ack", mat_valid, 0);
    chk("in_ready_ack", in_ready, 1);
  endtask

  initial begin
    vecs[0] = '{12'd1,   12'd11,  12'd1, 1'b0, 0, 12'd1,   12'd10,  12'd11,  12'd18};
    vecs[1] = '{12'd1,   12'd11,  12'd1, 1'b1, 5, 12'd1,   12'd10,  12'd11,  12'd18};
    vecs[2] = '{12'd100, 12'd200, 12'd1, 1'b0, 5, 12'd100, 12'd109, 12'd200, 12'd207};
    vecs[3] = '{12'hFFA, 12'h7F0, 12'd1, 1'b1, 1, 12'hFFA, 12'h003, 12'h7F0, 12'h7F7};
    vecs[4] = '{12'd2,   12'd3,   12'd0, 1'b0, 2, 12'd2,   12'd2,   12'd3,   12'd3};

    #12;
    chk("rst_a_bus", a_bus, 0);
    chk("rst_b_bus", b_bus, 0);
    chk("rst_mat_valid", mat_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // async reset after the 13th transfer, between edges
    load_set(12'd50, 12'd60, 12'd1, 1'b0, 13);
    #3 rst = 1'b1;
    #1;
    chk("arst_a_bus", a_bus, 0);
    chk("arst_b_bus", b_bus, 0);
    chk("arst_mat_valid", mat_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    run_vec(vecs[0]);

`ifdef MAT_LOADER_FLUSH_EN
    load_set(12'd70, 12'd80, 12'd1, 1'b0, 14);
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_mat_valid", mat_valid, 0);
    run_vec(vecs[2]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
